code25_serial_tx: RTL

- Transmit side of the team's 2-of-5 digit link.
- Accepts one BCD digit through a valid/ready handshake and encodes it into the 5-bit 2-of-5 code E1..E5.
- Shifts the code out serially, E1 first; each bit is held for a programmable number of clock cycles.
- Also presents the encoded code in parallel, for the 7-segment path and for loopback checks.

---
 rtl/code25_serial_tx_if.sv | 9 +
 rtl/code25_serial_tx.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/code25_serial_tx_if.sv
// Digit handshake between a BCD source and the 2-of-5 serial transmitter.
interface code25_serial_tx_if;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       digit_ready;

  modport master (output digit_in, output digit_valid, input digit_ready);
  modport slave  (input digit_in, input digit_valid, output digit_ready);
endinterface

// File: rtl/code25_serial_tx.sv
// 2-of-5 digit transmitter: encodes an accepted BCD digit and shifts E1..E5 out serially.
// Optional rejected-digit counter (err_count) is built when CODE25_ERRCNT_EN is defined.
module code25_serial_tx #(
  parameter int unsigned BIT_CYCLES = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  code25_serial_tx_if.slave dig,
  output logic              ser_out,
  output logic              frame_active,
  output logic [4:0]        code_out,
  output logic              err_invalid
`ifdef CODE25_ERRCNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  localparam int unsigned CNT_MAX  = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned BIT_LAST = BIT_CYCLES - 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [4:0]       shreg, shreg_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [4:0]       code_nxt;
  logic             err_nxt;
  logic             digit_ready_q;

  assign dig.digit_ready = digit_ready_q;

  // 2-of-5 code table, E1 in bit 4; non-BCD inputs never reach the shifter.
  function automatic logic [4:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 5'b00011;
      4'd1:    encode = 5'b00101;
      4'd2:    encode = 5'b11000;
      4'd3:    encode = 5'b01001;
      4'd4:    encode = 5'b01010;
      4'd5:    encode = 5'b10001;
      4'd6:    encode = 5'b00110;
      4'd7:    encode = 5'b10010;
      4'd8:    encode = 5'b01100;
      4'd9:    encode = 5'b10100;
      default: encode = 5'b00000;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath decisions
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_idx_nxt = bit_idx;
    cnt_nxt     = cnt;
    code_nxt    = code_out;
    err_nxt     = 1'b0;
    case (state)
      S_IDLE: begin
        if (dig.digit_valid) begin
          if (dig.digit_in <= 4'd9) begin
            shreg_nxt   = encode(dig.digit_in);
            code_nxt    = encode(dig.digit_in);
            bit_idx_nxt = 3'd0;
            cnt_nxt     = '0;
            state_nxt   = S_SEND;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_SEND: begin
        if (cnt == CNT_W'(BIT_LAST)) begin
          cnt_nxt = '0;
          if (bit_idx == 3'd4) begin
            state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            shreg_nxt   = {shreg[3:0], 1'b0};
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt == CNT_W'(GAP_LAST)) begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs, derived from the upcoming state so they align with it
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg         <= '0;
      bit_idx       <= '0;
      cnt           <= '0;
      code_out      <= '0;
      err_invalid   <= 1'b0;
      ser_out       <= 1'b0;
      frame_active  <= 1'b0;
      digit_ready_q <= 1'b1;
    end else begin
      shreg         <= shreg_nxt;
      bit_idx       <= bit_idx_nxt;
      cnt           <= cnt_nxt;
      code_out      <= code_nxt;
      err_invalid   <= err_nxt;
      ser_out       <= (state_nxt == S_SEND) && shreg_nxt[4];
      frame_active  <= (state_nxt == S_SEND);
      digit_ready_q <= (state_nxt == S_IDLE);
    end
  end

`ifdef CODE25_ERRCNT_EN
  // Saturating count of rejected digits
  always_ff @(posedge clk) begin
    if (rst)                            err_count <= '0;
    else if (err_nxt && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif

endmodule
